// File: rtl/acc_exec_stage_p.sv
// Execute stage of the accumulator processor: single-cycle ALU/branch ops,
// iterative shift-add multiply, PC-relative branching and a vectored interrupt.
module acc_exec_stage_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  instr_in,
    input  logic [2:0]        addr_mode_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              irq,
    input  logic [ADDR_W-1:0] irq_vector,
    output logic [DATA_W-1:0] acc_out,
    output logic              cout,
    output logic              zero,
    output logic              overflow,
    output logic [ADDR_W-1:0] next_pc,
    output logic              stage_complete,
    output logic              irq_ack,
    output logic              illegal
);

    localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(5'h00);
    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5'h01);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(5'h02);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(5'h03);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(5'h04);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5'h05);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5'h06);
    localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(5'h07);
    localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(5'h08);
    localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(5'h09);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5'h0A);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(5'h0B);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(5'h0C);
    localparam logic [OPC_W-1:0] OP_CLR = OPC_W'(5'h0D);
    localparam logic [OPC_W-1:0] OP_RTI = OPC_W'(5'h0E);
    localparam logic [OPC_W-1:0] OP_EI  = OPC_W'(5'h0F);
    localparam logic [OPC_W-1:0] OP_DI  = OPC_W'(5'h10);

    typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

    state_t              state;
    logic [DATA_W-1:0]   acc;
    logic [ADDR_W-1:0]   epc;
    logic                ie;
    logic [CNT_W-1:0]    mul_cnt;
    logic [2*DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0]   mul_mplier;
    logic [2*DATA_W-1:0] mul_prod;
    logic [2*DATA_W-1:0] mul_final;

    logic [DATA_W-1:0]   res_acc;
    logic                res_cout;
    logic                res_zero;
    logic                res_ovf;
    logic                res_ie;
    logic [ADDR_W-1:0]   res_pc;
    logic                res_illegal;
    logic                acc_wr;
    logic                is_mul;
    logic                take;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;

    // Two's-complement overflow of a + b giving s.
    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Two's-complement overflow of a - b giving d.
    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] d);
        return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // PC-relative target: address after the branch plus sign-extended offset.
    function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                     input logic signed [DATA_W-1:0] ofs);
        logic signed [EXT_W-1:0] ofs_ext;
        ofs_ext = EXT_W'(ofs);
        return pc + ADDR_W'(1) + ofs_ext[ADDR_W-1:0];
    endfunction

    assign in_ready  = (state == ST_IDLE);
    assign acc_out   = acc;
    assign mul_final = mul_prod + (mul_mplier[0] ? mul_mcand : '0);

    // Result of a single-cycle instruction, using flags as held before it.
    always_comb begin
        res_acc     = acc;
        res_cout    = cout;
        res_zero    = zero;
        res_ovf     = overflow;
        res_ie      = ie;
        res_pc      = pc_in + ADDR_W'(1);
        res_illegal = 1'b0;
        acc_wr      = 1'b0;
        is_mul      = 1'b0;
        take        = 1'b0;
        sum         = {1'b0, acc} + {1'b0, data_in};
        diff        = {1'b0, acc} - {1'b0, data_in};
        case (instr_in)
            OP_NOP: begin end
            OP_LDA: begin res_acc = data_in; acc_wr = 1'b1; end
            OP_ADD: begin
                res_acc  = sum[DATA_W-1:0];
                res_cout = sum[DATA_W];
                res_ovf  = add_ovf(acc, data_in, sum[DATA_W-1:0]);
                acc_wr   = 1'b1;
            end
            OP_SUB: begin
                res_acc  = diff[DATA_W-1:0];
                res_cout = diff[DATA_W];
                res_ovf  = sub_ovf(acc, data_in, diff[DATA_W-1:0]);
                acc_wr   = 1'b1;
            end
            OP_AND: begin res_acc = acc & data_in; acc_wr = 1'b1; end
            OP_OR:  begin res_acc = acc | data_in; acc_wr = 1'b1; end
            OP_XOR: begin res_acc = acc ^ data_in; acc_wr = 1'b1; end
            OP_SHL: begin
                res_acc  = acc << 1;
                res_cout = acc[DATA_W-1];
                res_ovf  = 1'b0;
                acc_wr   = 1'b1;
            end
            OP_SHR: begin
                res_acc  = acc >> 1;
                res_cout = acc[0];
                res_ovf  = 1'b0;
                acc_wr   = 1'b1;
            end
            OP_MUL: is_mul = 1'b1;
            OP_JMP, OP_JZ, OP_JC: begin
                take = (instr_in == OP_JMP) || ((instr_in == OP_JZ) && zero) ||
                       ((instr_in == OP_JC) && cout);
                if (addr_mode_in > 3'd1) begin
                    res_illegal = 1'b1;
                end else if (take) begin
                    res_pc = (addr_mode_in == 3'd0) ? ADDR_W'(data_in)
                                                    : rel_target(pc_in, data_in);
                end
            end
            OP_CLR: begin res_acc = '0; acc_wr = 1'b1; end
            OP_RTI: begin res_pc = epc; res_ie = 1'b1; end
            OP_EI:  res_ie = 1'b1;
            OP_DI:  res_ie = 1'b0;
            default: res_illegal = 1'b1;
        endcase
        if (acc_wr) begin
            res_zero = (res_acc == '0);
        end
    end

    // Architectural state, retire pulses and the IDLE/MUL sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            acc            <= '0;
            cout           <= 1'b0;
            zero           <= 1'b0;
            overflow       <= 1'b0;
            next_pc        <= '0;
            epc            <= '0;
            ie             <= 1'b0;
            mul_cnt        <= '0;
            stage_complete <= 1'b0;
            irq_ack        <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            stage_complete <= 1'b0;
            irq_ack        <= 1'b0;
            illegal        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        next_pc <= res_pc;
                        if (is_mul) begin
                            state   <= ST_MUL;
                            mul_cnt <= '0;
                        end else begin
                            acc            <= res_acc;
                            cout           <= res_cout;
                            zero           <= res_zero;
                            overflow       <= res_ovf;
                            ie             <= res_ie;
                            illegal        <= res_illegal;
                            stage_complete <= 1'b1;
                            if (irq && ie) begin
                                epc     <= res_pc;
                                next_pc <= irq_vector;
                                ie      <= 1'b0;
                                irq_ack <= 1'b1;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    mul_cnt <= mul_cnt + CNT_W'(1);
                    if (mul_cnt == CNT_W'(DATA_W - 1)) begin
                        state          <= ST_IDLE;
                        acc            <= mul_final[DATA_W-1:0];
                        cout           <= |mul_final[2*DATA_W-1:DATA_W];
                        overflow       <= 1'b0;
                        zero           <= (mul_final[DATA_W-1:0] == '0);
                        stage_complete <= 1'b1;
                        if (irq && ie) begin
                            epc     <= next_pc;
                            next_pc <= irq_vector;
                            ie      <= 1'b0;
                            irq_ack <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift-add multiply datapath: one multiplier bit consumed per cycle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid && is_mul) begin
            mul_mcand  <= {{DATA_W{1'b0}}, acc};
            mul_mplier <= data_in;
            mul_prod   <= '0;
        end else if (state == ST_MUL) begin
            mul_prod   <= mul_final;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end

endmodule

// File: tb/tb_acc_exec_stage_p.sv
// Bench for acc_exec_stage_p: directed scenarios followed by random
// instruction streams, all checked against an integer-level reference model.
module tb_acc_exec_stage_p;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int OPC_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OPC_W-1:0]  instr_in = '0;
    logic [2:0]        addr_mode_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] pc_in = '0;
    logic              irq = 1'b0;
    logic [ADDR_W-1:0] irq_vector = '0;
    logic [DATA_W-1:0] acc_out;
    logic              cout;
    logic              zero;
    logic              overflow;
    logic [ADDR_W-1:0] next_pc;
    logic              stage_complete;
    logic              irq_ack;
    logic              illegal;

    always #5 clk = ~clk;

    acc_exec_stage_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .addr_mode_in(addr_mode_in), .data_in(data_in),
        .pc_in(pc_in), .irq(irq), .irq_vector(irq_vector), .acc_out(acc_out),
        .cout(cout), .zero(zero), .overflow(overflow), .next_pc(next_pc),
        .stage_complete(stage_complete), .irq_ack(irq_ack), .illegal(illegal)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state (plain integers)
    int m_acc, m_c, m_z, m_v, m_ie, m_epc, m_pc, m_ill, m_ack;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int sgn8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_z = 0; m_v = 0; m_ie = 0;
        m_epc = 0; m_pc = 0; m_ill = 0; m_ack = 0;
    endtask

    task automatic model_exec(input int op, input int mode, input int d,
                              input int pc, input int irq_l, input int vec);
        int npc, ie_old, s, p, taken;
        bit wr;
        npc = (pc + 1) % 256;
        ie_old = m_ie;
        m_ill = 0; m_ack = 0; wr = 0;
        case (op)
            0: ;
            1: begin m_acc = d; wr = 1; end
            2: begin
                s = sgn8(m_acc) + sgn8(d);
                m_v = (s > 127 || s < -128) ? 1 : 0;
                m_c = (m_acc + d > 255) ? 1 : 0;
                m_acc = (m_acc + d) % 256; wr = 1;
            end
            3: begin
                s = sgn8(m_acc) - sgn8(d);
                m_v = (s > 127 || s < -128) ? 1 : 0;
                m_c = (m_acc < d) ? 1 : 0;
                m_acc = (m_acc - d + 256) % 256; wr = 1;
            end
            4: begin m_acc = m_acc & d; wr = 1; end
            5: begin m_acc = m_acc | d; wr = 1; end
            6: begin m_acc = m_acc ^ d; wr = 1; end
            7: begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; m_v = 0; wr = 1; end
            8: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_v = 0; wr = 1; end
            9: begin
                p = m_acc * d;
                m_acc = p % 256; m_c = (p > 255) ? 1 : 0; m_v = 0; wr = 1;
            end
            10, 11, 12: begin
                taken = (op == 10) || (op == 11 && m_z != 0) || (op == 12 && m_c != 0);
                if (mode > 1) m_ill = 1;
                else if (taken != 0) npc = (mode == 0) ? d : ((pc + 1 + sgn8(d)) % 256 + 256) % 256;
            end
            13: begin m_acc = 0; wr = 1; end
            14: begin npc = m_epc; m_ie = 1; end
            15: m_ie = 1;
            16: m_ie = 0;
            default: m_ill = 1;
        endcase
        if (wr) m_z = (m_acc == 0) ? 1 : 0;
        if (irq_l != 0 && ie_old != 0) begin
            m_epc = npc; npc = vec; m_ie = 0; m_ack = 1;
        end
        m_pc = npc;
    endtask

    task automatic check_all(input string tag, input int sc);
        check({tag, ".acc"}, int'(acc_out), m_acc);
        check({tag, ".cout"}, int'(cout), m_c);
        check({tag, ".zero"}, int'(zero), m_z);
        check({tag, ".ovf"}, int'(overflow), m_v);
        check({tag, ".npc"}, int'(next_pc), m_pc);
        check({tag, ".sc"}, int'(stage_complete), sc);
        check({tag, ".ack"}, int'(irq_ack), (sc != 0) ? m_ack : 0);
        check({tag, ".ill"}, int'(illegal), (sc != 0) ? m_ill : 0);
    endtask

    task automatic drive(input int op, input int mode, input int d,
                         input int pc, input int irq_l, input int vec);
        instr_in = OPC_W'(op); addr_mode_in = 3'(mode); data_in = DATA_W'(d);
        pc_in = ADDR_W'(pc); irq = (irq_l != 0); irq_vector = ADDR_W'(vec);
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic exec1(input string tag, input int op, input int mode, input int d,
                         input int pc, input int irq_l, input int vec);
        check({tag, ".rdy"}, int'(in_ready), 1);
        drive(op, mode, d, pc, irq_l, vec);
        @(posedge clk);
        model_exec(op, mode, d, pc, irq_l, vec);
        @(negedge clk);
        check_all(tag, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0; irq = 1'b0;
        @(negedge clk);
    endtask

    // Multiply with optional in_valid poke while busy; lat is cycles to retire.
    task automatic exec_mul(input string tag, input int d, input int pc, input int irq_l,
                            input int vec, input bit poke, output int lat);
        int ready_seen;
        drive(9, 0, d, pc, irq_l, vec);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".busy"}, int'(in_ready), 0);
        lat = 0; ready_seen = 0;
        while (stage_complete !== 1'b1 && lat < 40) begin
            if (poke && lat == 3) drive(1, 0, 8'h55, pc, irq_l, vec);
            if (poke && lat == 5) in_valid = 1'b0;
            @(negedge clk);
            lat++;
            if (stage_complete !== 1'b1 && in_ready === 1'b1) ready_seen = 1;
        end
        in_valid = 1'b0;
        check({tag, ".lat"}, lat, DATA_W);
        check({tag, ".rdy_low"}, ready_seen, 0);
        model_exec(9, 0, d, pc, irq_l, vec);
        check_all(tag, 1);
    endtask

    initial begin
        int lat, op, mode, r;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.rdy", int'(in_ready), 1);
        check_all("rst", 0);
        reset = 1'b1;
        @(negedge clk);

        // Plan 1: overflow into sign bit, back-to-back retire
        exec1("t1.lda", 1, 0, 8'h7F, 8'h10, 0, 0);
        exec1("t1.add", 2, 0, 8'h01, 8'h11, 0, 0);
        check("t1.acc80", int'(acc_out), 8'h80);
        check("t1.ovf1", int'(overflow), 1);
        check("t1.npc12", int'(next_pc), 8'h12);
        idle();
        check("t1.sc_drop", int'(stage_complete), 0);

        // Plan 2: borrow and clear
        exec1("t2.lda", 1, 0, 8'h00, 8'h12, 0, 0);
        exec1("t2.sub", 3, 0, 8'h01, 8'h13, 0, 0);
        check("t2.accFF", int'(acc_out), 8'hFF);
        check("t2.borrow", int'(cout), 1);
        exec1("t2.clr", 13, 0, 0, 8'h14, 0, 0);
        check("t2.zero1", int'(zero), 1);
        idle();

        // Plan 3: multiply 0x0D * 0x15 = 0x0111, busy-time poke ignored
        exec1("t3.lda", 1, 0, 8'h0D, 8'h15, 0, 0);
        idle();
        exec_mul("t3.mul", 8'h15, 8'h40, 0, 0, 1'b1, lat);
        check("t3.acc11", int'(acc_out), 8'h11);
        check("t3.cout1", int'(cout), 1);
        check("t3.npc41", int'(next_pc), 8'h41);

        // Plan 4: conditional and relative branches, illegal mode
        exec1("t4.lda", 1, 0, 8'h00, 8'h1E, 0, 0);
        exec1("t4.add", 2, 0, 8'h00, 8'h1F, 0, 0);
        exec1("t4.jz", 11, 1, 8'hFC, 8'h20, 0, 0);
        check("t4.npc1D", int'(next_pc), 8'h1D);
        exec1("t4.jc", 12, 0, 8'h99, 8'h21, 0, 0);
        check("t4.npc22", int'(next_pc), 8'h22);
        exec1("t4.jmp3", 10, 3, 8'h50, 8'h22, 0, 0);
        check("t4.ill", int'(illegal), 1);
        check("t4.npc23", int'(next_pc), 8'h23);
        idle();

        // Plan 5: interrupt entry, masking, return and re-enable
        exec1("t5.ei", 15, 0, 0, 8'h2F, 1, 8'h80);
        check("t5.ei_noack", int'(irq_ack), 0);
        exec1("t5.add", 2, 0, 8'h01, 8'h30, 1, 8'h80);
        check("t5.npc80", int'(next_pc), 8'h80);
        check("t5.ack", int'(irq_ack), 1);
        exec1("t5.masked", 0, 0, 0, 8'h80, 1, 8'h80);
        check("t5.noack", int'(irq_ack), 0);
        exec1("t5.rti", 14, 0, 0, 8'h81, 0, 0);
        check("t5.npc31", int'(next_pc), 8'h31);
        exec1("t5.reen", 0, 0, 0, 8'h31, 1, 8'h90);
        check("t5.ack2", int'(irq_ack), 1);
        idle();

        // Plan 6: async reset in the middle of a multiply, then illegal opcode
        exec1("t6.lda", 1, 0, 8'h0D, 8'h50, 0, 0);
        idle();
        drive(9, 0, 8'h15, 8'h51, 0, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("t6.rdy", int'(in_ready), 1);
        check_all("t6.rst", 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6.rdy_after", int'(in_ready), 1);
        exec1("t6.lda2", 1, 0, 8'h3C, 8'h60, 0, 0);
        exec1("t6.bad", 31, 0, 8'hAA, 8'h61, 0, 0);
        check("t6.ill", int'(illegal), 1);
        check("t6.acc3C", int'(acc_out), 8'h3C);
        idle();

        // Random instruction stream against the model
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            op = (r <= 16) ? r : int'($urandom_range(17, 31));
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 1));
            if (op == 9) begin
                exec_mul("rnd.mul", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 255)),
                         $urandom_range(0, 1) == 1, lat);
            end else begin
                exec1("rnd", op, mode, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/acc_exec_stage_p.md
Name: acc_exec_stage_p

Overview:
Parametrised execute stage for the accumulator-based processor. It takes one staged instruction per valid/ready handshake and executes it against the accumulator. Outputs are the accumulator, carry/zero/overflow flags, next PC and a stage-complete pulse. Additions are a generic data width, an iterative multi-cycle multiply, PC-relative branching and a vectored interrupt with return.

Parameters:
DATA_W, 8, accumulator/operand width (>=4)
ADDR_W, 8, PC / address width
OPC_W, 5, opcode field width (>=5)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  staged instruction present
in_ready  output  1  stage can accept (comb: state==IDLE)
instr_in  input  OPC_W  opcode
addr_mode_in  input  3  0=absolute, 1=PC-relative, others illegal for branches
data_in  input  DATA_W  operand / branch offset or target (low ADDR_W bits)
pc_in  input  ADDR_W  PC of staged instruction
irq  input  1  level interrupt request
irq_vector  input  ADDR_W  interrupt target address
acc_out  output  DATA_W  accumulator
cout  output  1  carry flag
zero  output  1  zero flag
overflow  output  1  signed overflow flag
next_pc  output  ADDR_W  registered next PC
stage_complete  output  1  one-cycle pulse per retired instruction
irq_ack  output  1  one-cycle pulse when interrupt taken
illegal  output  1  one-cycle pulse when an illegal opcode/mode retires

Behaviour:
- Reset (reset=0, async): acc, cout, zero, overflow, next_pc, epc, ie all 0; stage_complete, irq_ack and illegal all 0; state IDLE; multiply counter 0.
- States: IDLE and MUL. Accept = in_valid & in_ready at a rising edge.
- Single-cycle op accepted in IDLE:
  - Results, flags and next_pc registered at the accept edge.
  - stage_complete=1 in the following cycle.
  - Stays in IDLE, so back-to-back accepts give 1 instr/cycle.
- Opcodes (hex) and their effect:
  - 00 NOP; 01 LDA (acc=op); 02 ADD; 03 SUB; 04 AND; 05 OR; 06 XOR.
  - 07 SHL: cout=acc MSB. 08 SHR (logical): cout=acc LSB.
  - 09 MUL; 0A JMP; 0B JZ; 0C JC; 0D CLR; 0E RTI; 0F EI; 10 DI.
  - All other codes: executed as NOP with illegal=1.
- Arithmetic: ADD computes {cout,acc}=acc+op. SUB computes acc-op, with cout=1 meaning borrow. overflow uses two's-complement DATA_W rules. All arithmetic wraps modulo 2^DATA_W.
- Flags:
  - zero updates on every acc-writing op (LDA, ALU, MUL, CLR).
  - cout/overflow update only on ADD, SUB, SHL, SHR, MUL; overflow is cleared by SHL/SHR.
  - Other ops hold all flags. CLR clears acc and sets zero=1.
- MUL:
  - Accept moves the stage to MUL with a copy of acc and op; in_ready=0.
  - Shift-add, one bit per cycle, for DATA_W cycles.
  - At the DATA_W-th edge: acc = low half, cout = OR of high half, overflow=0. Return to IDLE.
  - stage_complete pulses the next cycle, so latency is DATA_W cycles.
- next_pc:
  - Default pc_in+1 (wraps).
  - JMP, and JZ/JC when the flag is set (flags as held before this instruction): target = data_in[ADDR_W-1:0] for mode 0, pc_in+1+sign-extended data_in for mode 1.
  - Branch with mode>=2: falls through, illegal=1.
- Interrupt:
  - Sampled at each retire edge (accept edge, or final MUL edge).
  - If irq & ie: epc<=computed next_pc, next_pc<=irq_vector, ie<=0, irq_ack=1 next cycle. The instruction still fully retires.
  - EI/DI set/clear ie effective for the next retire, not the same one.
  - RTI: next_pc<=epc, ie<=1.
- Reset asserted mid-MUL abandons the multiply and returns everything to reset values immediately.
- in_valid while in MUL is ignored. The instruction must be held until in_ready=1.

Test Plan:
1. Reset, then LDA 0x7F, ADD 0x01 back-to-back at pc 0x10,0x11 -> acc=0x80, overflow=1, cout=0, zero=0, next_pc=0x12; two consecutive stage_complete pulses.
2. LDA 0x00, SUB 0x01 -> acc=0xFF, cout=1 (borrow), overflow=0. Then CLR -> acc=0x00, zero=1.
3. LDA 0x0D, MUL 0x15 -> in_ready low 8 cycles, acc=0x11, cout=1 (0x0111), stage_complete exactly 8 cycles after accept. An in_valid pulse during MUL is not consumed.
4. With zero=1, JZ mode1 data 0xFC at pc 0x20 -> next_pc=0x1D. JC mode0 with cout=0 -> next_pc=pc+1. JMP mode 3 -> illegal=1, fall-through.
5. EI, then ADD with irq=1 and irq_vector=0x80 at pc 0x30 -> next_pc=0x80, irq_ack=1, ie=0 (a second irq is ignored). RTI -> next_pc=0x31, ie=1.
6. Assert reset 3 cycles into a MUL -> all outputs 0 asynchronously, in_ready=1 after release. Opcode 0x1F -> illegal=1, acc unchanged.
